// File: rtl/cpu_bus_pkg.sv
// Shared definitions for CPU data-bus masters and source arbiters.
package cpu_bus_pkg;

    localparam int CPU_DATA_W = 8;

    typedef enum logic {
        BUS_FIXED = 1'b0,
        BUS_RR    = 1'b1
    } bus_mode_e;

    // Low bit of source idx within a flat {src[N-1], ..., src[0]} data vector.
    function automatic int src_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    int idx;

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_src_arbiter.sv
// N-source bus mux with fixed or round-robin selection, optional owner lock,
// and a one-entry registered output with valid/ready handshake.
module bus_src_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int N_SRC  = 4,
    parameter int SEL_W  = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        b_sel,
    input  logic                    lock,
    output logic [DATA_W-1:0]       b_bus,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    output logic [SEL_W-1:0]        bus_owner
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [N_SRC-1:0]  eligible;
    logic [N_SRC-1:0]  req;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_vld;
    logic              load_en;
    logic              handshake;
    logic              rr_mode;
    logic [SEL_W-1:0]  ptr_next;
    logic [DATA_W-1:0] grant_data;

    assign rr_mode = (bus_mode_e'(mode) == BUS_RR);
    assign load_en = !bus_valid || bus_ready;

    always_comb begin
        eligible = '0;
        if (rr_mode) begin
            eligible = '1;
        end else if (int'(b_sel) < N_SRC) begin
            eligible[b_sel] = 1'b1;
        end
        // Lock only pins ownership while a word from the owner is still held.
        if (lock && bus_valid) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (i != int'(bus_owner)) eligible[i] = 1'b0;
            end
        end
    end

    assign req = eligible & src_valid;

    // In fixed mode at most one req bit is set, so the scan order is irrelevant.
    rr_arbiter #(
        .N     (N_SRC),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign handshake  = rst_n && load_en && grant_vld;
    assign grant_data = src_data[src_lo(int'(grant_idx), DATA_W) +: DATA_W];
    assign ptr_next   = (int'(grant_idx) == N_SRC - 1) ? '0 : grant_idx + 1'b1;

    always_comb begin
        src_ready = '0;
        if (handshake) src_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_bus     <= '0;
            bus_valid <= 1'b0;
            bus_owner <= '0;
            rr_ptr    <= '0;
        end else if (handshake) begin
            b_bus     <= grant_data;
            bus_owner <= grant_idx;
            bus_valid <= 1'b1;
            if (rr_mode) rr_ptr <= ptr_next;
        end else if (bus_ready) begin
            bus_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_src_arbiter.sv
// Directed test-plan scenarios followed by randomized traffic, all checked
// against a transaction-level reference model of the arbiter.
module tb_bus_src_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_valid;
    logic [N-1:0]   src_ready;
    logic           mode;
    logic [S-1:0]   b_sel;
    logic           lock;
    logic [W-1:0]   b_bus;
    logic           bus_valid;
    logic           bus_ready;
    logic [S-1:0]   bus_owner;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit       m_valid = 0;
    bit [7:0] m_data  = 0;
    int       m_owner = 0;
    int       m_ptr   = 0;

    bus_src_arbiter #(.DATA_W(W), .N_SRC(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .mode      (mode),
        .b_sel     (b_sel),
        .lock      (lock),
        .b_bus     (b_bus),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_owner (bus_owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Winner under the written rules: scan order from the pointer in RR mode,
    // eligibility from b_sel / lock, and the source must be offering a word.
    function automatic int model_grant();
        int g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            bit elig;
            i    = mode ? (m_ptr + k) % N : k;
            elig = mode ? 1'b1 : (int'(b_sel) == i);
            if (lock && m_valid && i != m_owner) elig = 1'b0;
            if (elig && src_valid[i] && g < 0) g = i;
        end
        return g;
    endfunction

    // Called just after a negedge input update; returns at the next negedge.
    task automatic cycle();
        int       g;
        bit       load;
        bit [3:0] er;
        #1;
        g    = model_grant();
        load = !m_valid || bus_ready;
        er   = (rst_n && load && g >= 0) ? 4'(1 << g) : 4'b0000;
        check("src_ready", 32'(src_ready), 32'(er));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_owner = 0; m_ptr = 0;
        end else if (load && g >= 0) begin
            m_valid = 1;
            m_data  = src_data[g*W +: W];
            m_owner = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (bus_ready) begin
            m_valid = 0;
        end
        #1;
        check("bus_valid", 32'(bus_valid), 32'(m_valid));
        check("b_bus",     32'(b_bus),     32'(m_data));
        check("bus_owner", 32'(bus_owner), 32'(m_owner));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; src_data = '0; src_valid = '0; mode = 0;
        b_sel = '0; lock = 0; bus_ready = 0;
        @(negedge clk);
        cycle();
        cycle();

        // Reset / idle
        rst_n = 1; bus_ready = 1;
        cycle();
        check("idle_b_bus", 32'(b_bus), 32'h00);
        check("idle_valid", 32'(bus_valid), 32'h0);
        check("idle_ready", 32'(src_ready), 32'h0);

        // Fixed select of source 2
        for (int i = 0; i < N; i++) src_data[i*W +: W] = 8'(8'h90 + i);
        src_data[2*W +: W] = 8'h96;
        mode = 0; b_sel = 2; src_valid = 4'b1111; bus_ready = 1;
        #1 check("fixed_ready", 32'(src_ready), 32'b0100);
        cycle();
        check("fixed_b_bus", 32'(b_bus), 32'h96);
        check("fixed_owner", 32'(bus_owner), 32'd2);

        // Round-robin fairness with wrap
        mode = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_owner", 32'(bus_owner), 32'(k % 4));
        end

        // Backpressure hold, then refill without a bubble
        mode = 0; b_sel = 0; src_valid = 4'b0001; src_data[0*W +: W] = 8'h26;
        cycle();
        check("bp_load", 32'(b_bus), 32'h26);
        bus_ready = 0; src_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_hold", 32'(b_bus), 32'h26);
            #1 check("bp_ready", 32'(src_ready), 32'h0);
        end
        mode = 1; bus_ready = 1; src_valid = 4'b0010; src_data[1*W +: W] = 8'h5E;
        cycle();
        check("bp_refill", 32'(b_bus), 32'h5E);
        check("bp_nobubble", 32'(bus_valid), 32'h1);

        // Lock with owner idle: drains, then release goes to source 2
        lock = 1; src_valid = 4'b1101;
        cycle();
        check("lock_drain", 32'(bus_valid), 32'h0);
        lock = 0;
        cycle();
        check("unlock_owner", 32'(bus_owner), 32'd2);
        lock = 1; bus_ready = 0;
        cycle();
        rst_n = 0;
        #1 check("rst_ready", 32'(src_ready), 32'h0);
        cycle();
        check("rst_b_bus", 32'(b_bus), 32'h0);
        check("rst_valid", 32'(bus_valid), 32'h0);
        check("rst_owner", 32'(bus_owner), 32'h0);
        rst_n = 1; lock = 0;
        cycle();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            mode      = 1'($urandom_range(0, 1));
            b_sel     = 2'($urandom_range(0, 3));
            lock      = ($urandom_range(0, 3) == 0);
            bus_ready = ($urandom_range(0, 2) != 0);
            src_valid = 4'($urandom);
            src_data  = 32'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
